// File: rtl/hwpe_stream_merge_buffered.sv
// hwpe_stream_merge_buffered: merges NB_IN_STREAMS lanes, each behind its own FIFO, into one wide stream.
// Define HWPE_STREAM_MERGE_BUFFERED_STATUS_EN to expose per-lane counts and a skew-stall flag.
module hwpe_stream_merge_buffered #(
    parameter int unsigned DATA_WIDTH_IN = 8,
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic [NB_IN_STREAMS-1:0]                   lane_en_i,
    input  logic [NB_IN_STREAMS-1:0]                   push_valid_i,
    output logic [NB_IN_STREAMS-1:0]                   push_ready_o,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     push_data_i,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   push_strb_i,
    output logic                                       pop_valid_o,
    input  logic                                       pop_ready_i,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     pop_data_o,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   pop_strb_o
`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
    ,
    output logic [NB_IN_STREAMS*$clog2(FIFO_DEPTH+1)-1:0] lane_count_o,
    output logic                                       skew_stall_o
`endif
);
    localparam int unsigned DW = DATA_WIDTH_IN;
    localparam int unsigned SW = DATA_WIDTH_IN / 8;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic                     flush;
    logic                     pop;
    logic [NB_IN_STREAMS-1:0] nonempty;
    logic [NB_IN_STREAMS*CW-1:0] counts;

    assign flush       = rst_i | clear_i;
    // disabled lanes count as ready so they never block the merge
    assign pop_valid_o = !flush && (|lane_en_i) && (&(nonempty | ~lane_en_i));
    assign pop         = pop_valid_o && pop_ready_i;

`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
    assign lane_count_o = flush ? '0 : counts;
    assign skew_stall_o = !flush && (|(nonempty & lane_en_i)) && !pop_valid_o;
`endif

    for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : g_lane
        logic [DW-1:0] mem_data [FIFO_DEPTH];
        logic [SW-1:0] mem_strb [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] count;
        logic          wr, rd;

        assign push_ready_o[i]            = !flush && lane_en_i[i] && count != FULL;
        assign wr                         = push_valid_i[i] && push_ready_o[i];
        assign rd                         = pop && lane_en_i[i];
        assign nonempty[i]                = count != '0;
        assign counts[i*CW +: CW]         = count;
        assign pop_data_o[i*DW +: DW]     = lane_en_i[i] ? mem_data[rd_ptr] : '0;
        assign pop_strb_o[i*SW +: SW]     = lane_en_i[i] ? mem_strb[rd_ptr] : '0;

        // power-of-two depth lets the pointers wrap by plain overflow
        always_ff @(posedge clk_i) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(wr);
                rd_ptr <= rd_ptr + PW'(rd);
                count  <= count + CW'(wr) - CW'(rd);
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr) begin
                mem_data[wr_ptr] <= push_data_i[i*DW +: DW];
                mem_strb[wr_ptr] <= push_strb_i[i*SW +: SW];
            end
        end
    end
endmodule

// File: tb/tb_hwpe_stream_merge_buffered.sv
// tb_hwpe_stream_merge_buffered: directed scenarios plus randomized traffic against a queue-based model.
module tb_hwpe_stream_merge_buffered;
    localparam int DW = 8;
    localparam int NB = 2;
    localparam int D  = 4;
    localparam int SW = DW / 8;

    logic clk = 0, rst = 1, clear = 0, pop_ready = 0;
    logic [NB-1:0] lane_en = '0, push_valid = '0, push_ready;
    logic [NB*DW-1:0] push_data = '0, pop_data;
    logic [NB*SW-1:0] push_strb = '0, pop_strb;
    logic pop_valid;
`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
    logic [NB*$clog2(D+1)-1:0] lane_count;
    logic skew_stall;
`endif

    int checks = 0, errors = 0;
    logic [DW+SW-1:0] q [NB][$];
    logic [NB-1:0] exp_ready;
    logic exp_valid;
    logic [NB*DW-1:0] exp_data;
    logic [NB*SW-1:0] exp_strb;

    always #5 clk = ~clk;

    hwpe_stream_merge_buffered #(.DATA_WIDTH_IN(DW), .NB_IN_STREAMS(NB), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .lane_en_i(lane_en),
        .push_valid_i(push_valid), .push_ready_o(push_ready), .push_data_i(push_data),
        .push_strb_i(push_strb), .pop_valid_o(pop_valid), .pop_ready_i(pop_ready),
        .pop_data_o(pop_data), .pop_strb_o(pop_strb)
`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
        , .lane_count_o(lane_count), .skew_stall_o(skew_stall)
`endif
    );

    function automatic void model_eval();
        logic f;
        logic [DW+SW-1:0] h;
        f = rst | clear;
        exp_valid = !f && (lane_en != 0);
        exp_data = '0;
        exp_strb = '0;
        for (int i = 0; i < NB; i++) begin
            exp_ready[i] = !f && lane_en[i] && q[i].size() < D;
            if (lane_en[i]) begin
                if (q[i].size() == 0) exp_valid = 0;
                else begin
                    h = q[i][0];
                    exp_data[i*DW +: DW] = h[DW-1:0];
                    exp_strb[i*SW +: SW] = h[DW +: SW];
                end
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        if (rst || clear) begin
            for (int i = 0; i < NB; i++) q[i].delete();
        end else begin
            for (int i = 0; i < NB; i++)
                if (push_valid[i] && exp_ready[i])
                    q[i].push_back({push_strb[i*SW +: SW], push_data[i*DW +: DW]});
            if (exp_valid && pop_ready)
                for (int i = 0; i < NB; i++) if (lane_en[i]) q[i].delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; push_valid = '0; pop_ready = 0;
        #1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; lane_en = 2'b11; push_valid = 2'b11; pop_ready = 1;
        #1;
        checks++; if (push_ready !== 2'b00) begin errors++; $display("FAIL reset push_ready: got %b want 00", push_ready); end
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset pop_valid: got %b want 0", pop_valid); end
        tick();
        rst = 0; push_valid = '0;
        #1;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL post-reset pop_valid: got %b want 0", pop_valid); end
    endtask

    task automatic test_smoke();
        lane_en = 2'b11; push_valid = 2'b11; push_data = 16'h2211; push_strb = 2'b11; pop_ready = 1;
        #1;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL smoke early valid: got %b want 0", pop_valid); end
        tick();
        push_valid = '0;
        #1;
        checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL smoke valid: got %b want 1", pop_valid); end
        checks++; if (pop_data !== 16'h2211 || pop_strb !== 2'b11) begin errors++; $display("FAIL smoke data: got %h/%b want 2211/11", pop_data, pop_strb); end
        tick();
        #1;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL smoke drained: got %b want 0", pop_valid); end
    endtask

    task automatic test_skew();
        logic [NB*DW-1:0] got [$];
        int first = -1;
        lane_en = 2'b11; pop_ready = 1; push_strb = 2'b11;
        for (int c = 0; c < 10; c++) begin
            push_valid = {c >= 5 && c <= 7, c <= 2};
            push_data = {8'(8'hB0 + c - 5), 8'(8'hA0 + c)};
            #1;
            model_eval();
            checks++; if (pop_valid !== exp_valid) begin errors++; $display("FAIL skew valid c%0d: got %b want %b", c, pop_valid, exp_valid); end
`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
            if (c == 3) begin
                checks++; if (skew_stall !== 1'b1) begin errors++; $display("FAIL skew_stall: got %b want 1", skew_stall); end
            end
`endif
            if (pop_valid) begin
                if (first < 0) first = c;
                got.push_back(pop_data);
            end
            tick();
        end
        push_valid = '0;
        checks++; if (first != 6) begin errors++; $display("FAIL skew first valid cycle: got %0d want 6", first); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL skew count: got %0d want 3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++;
            if (got[k] !== {8'(8'hB0 + k), 8'(8'hA0 + k)}) begin errors++; $display("FAIL skew word%0d: got %h want %h", k, got[k], {8'(8'hB0 + k), 8'(8'hA0 + k)}); end
        end
    endtask

    task automatic test_full();
        logic [NB*DW-1:0] got [$];
        int acc = 0;
        do_reset();
        lane_en = 2'b11; pop_ready = 0; push_strb = 2'b11;
        for (int c = 0; c < 6; c++) begin
            push_valid = 2'b01;
            push_data = {8'h00, 8'(8'hC0 + acc)};
            #1;
            if (push_ready[0]) acc++;
            tick();
        end
        #1;
        checks++; if (acc != 4 || push_ready[0] !== 1'b0) begin errors++; $display("FAIL full accept: got %0d ready %b want 4 ready 0", acc, push_ready[0]); end
        pop_ready = 1;
        for (int c = 0; c < 8; c++) begin
            push_valid = {c < 4, acc < 5};
            push_data = {8'(8'hD0 + c), 8'(8'hC0 + acc)};
            #1;
            model_eval();
            if (c == 0) begin
                checks++; if (push_ready[0] !== 1'b0) begin errors++; $display("FAIL full no push-on-full: got %b want 0", push_ready[0]); end
            end
            checks++; if (pop_valid !== exp_valid) begin errors++; $display("FAIL full valid c%0d: got %b want %b", c, pop_valid, exp_valid); end
            if (pop_valid) got.push_back(pop_data);
            if (push_ready[0] && push_valid[0]) acc++;
            tick();
        end
        push_valid = '0;
        checks++; if (got.size() != 4 || acc != 5) begin errors++; $display("FAIL full drain: got %0d words acc %0d want 4/5", got.size(), acc); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            checks++;
            if (got[k] !== {8'(8'hD0 + k), 8'(8'hC0 + k)}) begin errors++; $display("FAIL full word%0d: got %h want %h", k, got[k], {8'(8'hD0 + k), 8'(8'hC0 + k)}); end
        end
        do_reset();
    endtask

    task automatic test_wrap();
        int n = 0;
        lane_en = 2'b11; pop_ready = 1; push_strb = 2'b11;
        for (int c = 0; c < 12; c++) begin
            push_valid = c < 10 ? 2'b11 : 2'b00;
            push_data = {8'(8'h80 + c), 8'(c)};
            #1;
            if (c >= 1 && c <= 10) begin
                checks++;
                if (pop_valid !== 1'b1 || pop_data !== {8'(8'h80 + c - 1), 8'(c - 1)})
                    begin errors++; $display("FAIL wrap c%0d: got %b/%h want 1/%h", c, pop_valid, pop_data, {8'(8'h80 + c - 1), 8'(c - 1)}); end
            end
            if (pop_valid) n++;
            tick();
        end
        push_valid = '0;
        checks++; if (n != 10) begin errors++; $display("FAIL wrap count: got %0d want 10", n); end
    endtask

    task automatic test_mask();
        lane_en = 2'b01; push_valid = 2'b11; push_data = 16'hEE5A; push_strb = 2'b11; pop_ready = 1;
        #1;
        checks++; if (push_ready !== 2'b01) begin errors++; $display("FAIL mask push_ready: got %b want 01", push_ready); end
        tick();
        push_valid = '0;
        #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== 16'h005A || pop_strb !== 2'b01)
            begin errors++; $display("FAIL mask output: got %b/%h/%b want 1/005a/01", pop_valid, pop_data, pop_strb); end
        tick();
        lane_en = 2'b00;
        #1;
        checks++; if (push_ready !== 2'b00 || pop_valid !== 1'b0) begin errors++; $display("FAIL zero mask: got %b/%b want 00/0", push_ready, pop_valid); end
    endtask

    task automatic test_clear();
        lane_en = 2'b11; pop_ready = 0; push_strb = 2'b11;
        for (int c = 0; c < 3; c++) begin
            push_valid = 2'b01; push_data = {8'h00, 8'(8'h30 + c)};
            #1;
            tick();
        end
        clear = 1; push_valid = 2'b11; pop_ready = 1;
        #1;
        checks++; if (push_ready !== 2'b00 || pop_valid !== 1'b0) begin errors++; $display("FAIL clear outputs: got %b/%b want 00/0", push_ready, pop_valid); end
        tick();
        clear = 0; push_valid = 2'b00;
        #1;
`ifdef HWPE_STREAM_MERGE_BUFFERED_STATUS_EN
        checks++; if (lane_count !== '0) begin errors++; $display("FAIL clear lane_count: got %h want 0", lane_count); end
`endif
        push_valid = 2'b01;
        #1;
        checks++; if (pop_valid !== 1'b0 || push_ready !== 2'b11) begin errors++; $display("FAIL after clear: got %b/%b want 0/11", pop_valid, push_ready); end
        push_valid = 2'b11; push_data = 16'h0201;
        tick();
        push_valid = '0;
        #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== 16'h0201) begin errors++; $display("FAIL clear fresh pair: got %b/%h want 1/0201", pop_valid, pop_data); end
        tick();
    endtask

    task automatic test_random();
        lane_en = 2'b11;
        for (int c = 0; c < 400; c++) begin
            model_eval();
            if (!exp_valid && $urandom_range(0, 7) == 0) lane_en = NB'($urandom);
            clear = $urandom_range(0, 59) == 0;
            push_valid = NB'($urandom);
            push_data = NB*DW'($urandom);
            push_strb = NB*SW'($urandom);
            pop_ready = $urandom_range(0, 3) != 0;
            #1;
            model_eval();
            checks++; if (push_ready !== exp_ready) begin errors++; $display("FAIL random push_ready c%0d: got %b want %b", c, push_ready, exp_ready); end
            checks++; if (pop_valid !== exp_valid) begin errors++; $display("FAIL random pop_valid c%0d: got %b want %b", c, pop_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (pop_data !== exp_data || pop_strb !== exp_strb)
                    begin errors++; $display("FAIL random data c%0d: got %h/%b want %h/%b", c, pop_data, pop_strb, exp_data, exp_strb); end
            end
            tick();
        end
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_smoke();
        test_skew();
        test_full();
        test_wrap();
        test_mask();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
